// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals between two requesters, a shared ALU and the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH_P  = 32,
  parameter int unsigned CNTRL_WIDTH_P = 3
);
  logic [1:0]                 i_req_valid;
  logic [1:0]                 o_req_ready;
  logic [2*CNTRL_WIDTH_P-1:0] i_req_control;
  logic [2*DATA_WIDTH_P-1:0]  i_req_a;
  logic [2*DATA_WIDTH_P-1:0]  i_req_b;
  logic [CNTRL_WIDTH_P-1:0]   o_alu_control;
  logic [DATA_WIDTH_P-1:0]    o_alu_a;
  logic [DATA_WIDTH_P-1:0]    o_alu_b;
  logic [DATA_WIDTH_P-1:0]    i_alu_result;
  logic                       o_rsp_valid;
  logic                       o_rsp_id;
  logic [DATA_WIDTH_P-1:0]    o_rsp_data;
  logic                       o_rsp_err;
  logic                       i_rsp_ready;

  // Arbiter side
  modport slave (
    input  i_req_valid, i_req_control, i_req_a, i_req_b, i_alu_result, i_rsp_ready,
    output o_req_ready, o_alu_control, o_alu_a, o_alu_b,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );

  // Requesters, ALU and response consumer side
  modport master (
    output i_req_valid, i_req_control, i_req_a, i_req_b, i_alu_result, i_rsp_ready,
    input  o_req_ready, o_alu_control, o_alu_a, o_alu_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight, registered response with illegal-opcode flag.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH_P  = 32,
  parameter int unsigned CNTRL_WIDTH_P = 3
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH_P;
  localparam int unsigned CW = CNTRL_WIDTH_P;

  localparam logic [CW-1:0] OP_AND = CW'(3'b000);
  localparam logic [CW-1:0] OP_OR  = CW'(3'b001);
  localparam logic [CW-1:0] OP_ADD = CW'(3'b010);
  localparam logic [CW-1:0] OP_SUB = CW'(3'b110);
  localparam logic [CW-1:0] OP_SLT = CW'(3'b111);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [CW-1:0]   control_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic            id_q;
  logic            last_q;

  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_err_q;

  logic            accept_c;
  logic            capture_c;
  logic            release_c;
  logic            grant_id_c;
  logic [1:0]      grant_c;

  logic [CW-1:0]   sel_control_c;
  logic [DW-1:0]   sel_a_c;
  logic [DW-1:0]   sel_b_c;
  logic            illegal_c;

  function automatic logic is_legal(input logic [CW-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, round-robin grant and datapath enables
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    release_c  = 1'b0;
    grant_id_c = 1'b0;
    grant_c    = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid != 2'b00) begin
          // On a tie the requester not granted last time wins
          if (bus.i_req_valid == 2'b11) begin
            grant_id_c = ~last_q;
          end else begin
            grant_id_c = bus.i_req_valid[1];
          end
          grant_c  = {grant_id_c, ~grant_id_c};
          accept_c = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand mux for the requester being granted
  always_comb begin
    sel_control_c = bus.i_req_control[CW-1:0];
    sel_a_c       = bus.i_req_a[DW-1:0];
    sel_b_c       = bus.i_req_b[DW-1:0];
    if (grant_id_c) begin
      sel_control_c = bus.i_req_control[2*CW-1:CW];
      sel_a_c       = bus.i_req_a[2*DW-1:DW];
      sel_b_c       = bus.i_req_b[2*DW-1:DW];
    end
  end

  assign illegal_c = ~is_legal(control_q);

  // Latched request, grant pointer and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      control_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        control_q <= sel_control_c;
        a_q       <= sel_a_c;
        b_q       <= sel_b_c;
        id_q      <= grant_id_c;
        last_q    <= grant_id_c;
      end
      if (capture_c) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_err_q   <= illegal_c;
        rsp_data_q  <= illegal_c ? '0 : bus.i_alu_result;
      end
      if (release_c) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Ready is combinational and suppressed while reset is high
  assign bus.o_req_ready   = reset ? 2'b00 : grant_c;

  assign bus.o_alu_control = control_q;
  assign bus.o_alu_a       = a_q;
  assign bus.o_alu_b       = b_q;

  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_id      = rsp_id_q;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, tie/backpressure/reset sequences,
// scoreboard queue of expected responses checked by a negedge monitor.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  logic clk;
  logic reset;
  int unsigned cyc;
  int checks;
  int failures;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  typedef struct {
    int            id;
    logic [CW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  rsp_t        exp_q[$];
  int unsigned gq[$];
  logic        busy;
  logic        seen;
  logic        tb_last;
  int          grant_cnt;
  vec_t        tbl[10];

  alu_arbiter_if #(.DATA_WIDTH_P(DW), .CNTRL_WIDTH_P(CW)) bus ();

  alu_arbiter #(.DATA_WIDTH_P(DW), .CNTRL_WIDTH_P(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference shared ALU; illegal codes return garbage the arbiter must zero
  always_comb begin
    case (bus.o_alu_control)
      3'b010:  bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
      3'b110:  bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
      3'b000:  bus.i_alu_result = bus.o_alu_a & bus.o_alu_b;
      3'b001:  bus.i_alu_result = bus.o_alu_a | bus.o_alu_b;
      3'b111:  bus.i_alu_result = DW'(bus.o_alu_a < bus.o_alu_b);
      default: bus.i_alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Checks grant order, ready gating, latency and response contents every cycle
  task automatic monitor();
    rsp_t        e;
    logic        w;
    int unsigned g;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("ready_in_reset", 64'(bus.o_req_ready), 64'd0);
        exp_q.delete();
        gq.delete();
        busy    = 1'b0;
        seen    = 1'b0;
        tb_last = 1'b1;
      end else if (busy) begin
        chk("ready_while_busy", 64'(bus.o_req_ready), 64'd0);
        if (bus.o_rsp_valid) begin
          if (!seen) begin
            seen = 1'b1;
            if (gq.size() > 0) begin
              g = gq.pop_front();
              chk("latency", 64'(cyc), 64'(g + 2));
            end
          end
          if (bus.i_rsp_ready) begin
            if (exp_q.size() == 0) begin
              chk("rsp_without_expectation", 64'(exp_q.size()), 64'd1);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_id", 64'(bus.o_rsp_id), 64'(e.id));
              chk("rsp_data", 64'(bus.o_rsp_data), 64'(e.data));
              chk("rsp_err", 64'(bus.o_rsp_err), 64'(e.err));
            end
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end else begin
        chk("rsp_valid_idle", 64'(bus.o_rsp_valid), 64'd0);
        if (bus.i_req_valid != 2'b00) begin
          w = (bus.i_req_valid == 2'b11) ? ~tb_last : bus.i_req_valid[1];
          chk("grant", 64'(bus.o_req_ready), w ? 64'd2 : 64'd1);
          gq.push_back(cyc);
          busy    = 1'b1;
          tb_last = w;
          grant_cnt++;
        end
      end
    end
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] d, input logic err);
    rsp_t e;
    e.id   = id[0];
    e.data = d;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int id, input logic [CW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    bus.i_req_control[id*CW +: CW] = op;
    bus.i_req_a[id*DW +: DW]       = a;
    bus.i_req_b[id*DW +: DW]       = b;
    bus.i_req_valid[id]            = 1'b1;
  endtask

  // Waits for the requester's ready, then withdraws its valid after the accepting edge
  task automatic wait_grant(input int id);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = bus.o_req_ready[id];
      n++;
    end
    chk("grant_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    bus.i_req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_done", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    push_exp(v.id, v.exp_data, v.exp_err);
    drive(v.id, v.op, v.a, v.b);
    wait_grant(v.id);
    wait_done(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vec_t v;
    tbl[0] = '{0, 3'b010, 32'd5,          32'd7,          32'd12,         1'b0};
    tbl[1] = '{1, 3'b011, 32'd1,          32'd2,          32'd0,          1'b1};
    tbl[2] = '{1, 3'b111, 32'd3,          32'd9,          32'd1,          1'b0};
    tbl[3] = '{1, 3'b111, 32'd9,          32'd3,          32'd0,          1'b0};
    tbl[4] = '{0, 3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    tbl[5] = '{0, 3'b000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    tbl[6] = '{1, 3'b001, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0};
    tbl[7] = '{0, 3'b100, 32'd4,          32'd4,          32'd0,          1'b1};
    tbl[8] = '{1, 3'b010, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0};
    tbl[9] = '{0, 3'b111, 32'h8000_0000,  32'd1,          32'd0,          1'b0};

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    busy      = 1'b0;
    seen      = 1'b0;
    tb_last   = 1'b1;
    grant_cnt = 0;
    reset             = 1'b1;
    bus.i_req_valid   = 2'b11;
    bus.i_req_control = '0;
    bus.i_req_a       = '0;
    bus.i_req_b       = '0;
    bus.i_rsp_ready   = 1'b1;

    fork
      monitor();
    join_none

    // Reset state with both requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.o_rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(bus.o_rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(bus.o_rsp_err), 64'd0);
    chk("rst_alu_ctrl", 64'(bus.o_alu_control), 64'd0);
    chk("rst_alu_a", 64'(bus.o_alu_a), 64'd0);
    chk("rst_alu_b", 64'(bus.o_alu_b), 64'd0);
    @(posedge clk);
    #1;
    bus.i_req_valid = 2'b00;
    reset           = 1'b0;
    @(posedge clk);
    #1;

    // Tie: both valid continuously, grants alternate starting with requester 0
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 32'd7, 1'b0);
      push_exp(1, 32'hFF, 1'b0);
    end
    grant_cnt = 0;
    drive(0, 3'b110, 32'd10, 32'd3);
    drive(1, 3'b001, 32'hF0, 32'h0F);
    n = 0;
    while (grant_cnt < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tie_grants", 64'(grant_cnt), 64'd4);
    @(posedge clk);
    #1;
    bus.i_req_valid = 2'b00;
    wait_done(20);

    // Vector table, one request at a time
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i]);
    end

    // Backpressure: response held, waiting requester 0 must not be granted
    bus.i_rsp_ready = 1'b0;
    push_exp(1, 32'd123, 1'b0);
    drive(1, 3'b010, 32'd100, 32'd23);
    wait_grant(1);
    push_exp(0, 32'd3, 1'b0);
    drive(0, 3'b001, 32'd1, 32'd2);
    n = 0;
    while (!bus.o_rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      chk("bp_valid", 64'(bus.o_rsp_valid), 64'd1);
      chk("bp_id", 64'(bus.o_rsp_id), 64'd1);
      chk("bp_data", 64'(bus.o_rsp_data), 64'd123);
      chk("bp_ready", 64'(bus.o_req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b1;
    wait_grant(0);
    wait_done(20);

    // Reset during EXEC discards the operation
    drive(0, 3'b010, 32'd1, 32'd1);
    wait_grant(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_alu_a", 64'(bus.o_alu_a), 64'd0);
    repeat (4) begin
      chk("mid_rst_no_rsp", 64'(bus.o_rsp_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    v = '{0, 3'b000, 32'hFF, 32'h0F, 32'h0F, 1'b0};
    issue(v);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
